// File: rtl/flow_resolve.sv
// flow_resolve: second stage of the flow (control-transfer) pipe.
// Resolves branch conditions, computes jump/branch targets, writes the
// JAL/JALR link value, and holds a redirect request to the front end
// until the front end accepts it. Redirects that resolve while a
// redirect is still outstanding are wrong-path and are dropped.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   instruction_i       flow op from operand read (FLOW_NOP = no op)
//   wb_valid/addr/data  link register write (value = pc_4)
//   redirect_valid/pc   held redirect request; redirect_ready accepts it
//   exc_valid/exc_pc    one-cycle misaligned-target exception
//   redirect_count      number of accepted redirects (wraps)

package flow_pkg;
  typedef enum logic [1:0] {
    FLOW_NOP    = 2'd0,
    FLOW_JAL    = 2'd1,
    FLOW_JALR   = 2'd2,
    FLOW_BRANCH = 2'd3
  } flow_func_t;

  typedef enum logic [2:0] {
    BEQ      = 3'd0,
    BNE      = 3'd1,
    BLT      = 3'd2,
    BGE      = 3'd3,
    BLTU     = 3'd4,
    BGEU     = 3'd5,
    BINVALID = 3'd6
  } branch_type_t;

  typedef struct packed {
    flow_func_t   flow_func;
    branch_type_t branch_type;
    logic [31:0]  pc_lhs;
    logic [31:0]  pc_rhs;
    logic [31:0]  branch_lhs;
    logic [31:0]  branch_rhs;
    logic [31:0]  pc_4;
    logic [6:0]   rd;
  } INSTRUCTION_FLOW;

  // Stage A contents.
  typedef struct packed {
    flow_func_t  func;
    logic [31:0] target;
    logic        taken;
    logic [6:0]  rd;
    logic [31:0] pc_4;
  } stage_a_t;
endpackage

module flow_resolve
  import flow_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  INSTRUCTION_FLOW instruction_i,
  output logic            wb_valid,
  output logic [6:0]      wb_addr,
  output logic [31:0]     wb_data,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  input  logic            redirect_ready,
  output logic            exc_valid,
  output logic [31:0]     exc_pc,
  output logic [31:0]     redirect_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  stage_a_t a_q, a_d;
  state_t   state;
  logic     misalign, redirect_req, is_jump;

  // Stage A: target adder and condition evaluation.
  always_comb begin
    a_d        = '0;
    a_d.func   = instruction_i.flow_func;
    a_d.rd     = instruction_i.rd;
    a_d.pc_4   = instruction_i.pc_4;
    a_d.target = instruction_i.pc_lhs + instruction_i.pc_rhs;
    if (instruction_i.flow_func == FLOW_JALR) a_d.target[0] = 1'b0;
    unique case (instruction_i.flow_func)
      FLOW_JAL, FLOW_JALR: a_d.taken = 1'b1;
      FLOW_BRANCH: begin
        unique case (instruction_i.branch_type)
          BEQ:  a_d.taken = instruction_i.branch_lhs == instruction_i.branch_rhs;
          BNE:  a_d.taken = instruction_i.branch_lhs != instruction_i.branch_rhs;
          BLT:  a_d.taken = $signed(instruction_i.branch_lhs) <  $signed(instruction_i.branch_rhs);
          BGE:  a_d.taken = $signed(instruction_i.branch_lhs) >= $signed(instruction_i.branch_rhs);
          BLTU: a_d.taken = instruction_i.branch_lhs <  instruction_i.branch_rhs;
          BGEU: a_d.taken = instruction_i.branch_lhs >= instruction_i.branch_rhs;
          default: a_d.taken = 1'b0;  // BINVALID and unused encodings
        endcase
      end
      default: a_d.taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) a_q <= '0;  // discards any in-flight op
    else        a_q <= a_d;
  end

  assign misalign     = a_q.taken & a_q.target[1];
  assign redirect_req = a_q.taken & ~misalign;
  assign is_jump      = (a_q.func == FLOW_JAL) || (a_q.func == FLOW_JALR);

  // Stage B: writeback / exception outputs. Writeback ignores redirect
  // state on purpose; rename makes wrong-path link writes harmless.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_pc    <= '0;
    end else begin
      wb_valid  <= is_jump && (a_q.rd != 7'd0) && !misalign;
      wb_addr   <= a_q.rd;
      wb_data   <= a_q.pc_4;
      exc_valid <= misalign;
      exc_pc    <= a_q.target;
    end
  end

  // Redirect FSM. While in HOLD every new request is wrong-path, including
  // one arriving on the accepting edge, so it is simply not loaded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_count <= '0;
    end else begin
      if (redirect_valid && redirect_ready) redirect_count <= redirect_count + 32'd1;
      unique case (state)
        IDLE: begin
          if (redirect_req) begin
            redirect_pc    <= a_q.target;
            redirect_valid <= 1'b1;
            state          <= HOLD;
          end else begin
            redirect_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_resolve.sv
// Directed-vector bench for flow_resolve with hand-computed expectations.
module tb_flow_resolve;
  import flow_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  INSTRUCTION_FLOW instruction_i;
  logic            wb_valid;
  logic [6:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            redirect_ready;
  logic            exc_valid;
  logic [31:0]     exc_pc;
  logic [31:0]     redirect_count;

  int n_cmp = 0;
  int n_err = 0;

  flow_resolve dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_i  (instruction_i),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic INSTRUCTION_FLOW mk(input flow_func_t f, input branch_type_t bt,
                                         input logic [31:0] pl, input logic [31:0] pr,
                                         input logic [31:0] bl, input logic [31:0] br,
                                         input logic [31:0] p4, input logic [6:0] rd);
    INSTRUCTION_FLOW i;
    i.flow_func   = f;
    i.branch_type = bt;
    i.pc_lhs      = pl;
    i.pc_rhs      = pr;
    i.branch_lhs  = bl;
    i.branch_rhs  = br;
    i.pc_4        = p4;
    i.rd          = rd;
    return i;
  endfunction

  function automatic INSTRUCTION_FLOW nop;
    return mk(FLOW_NOP, BEQ, 0, 0, 0, 0, 0, 0);
  endfunction

  // Issue one branch, check redirect at E+1 and let it drain (ready=1).
  task automatic run_br(input string tag, input branch_type_t bt,
                        input logic [31:0] bl, input logic [31:0] br, input logic exp_rv);
    instruction_i = mk(FLOW_BRANCH, bt, 32'h1000, 32'h40, bl, br, 32'h0, 7'd9);
    tick;
    instruction_i = nop();
    tick;
    chk({tag, "_rv"}, {31'b0, redirect_valid}, {31'b0, exp_rv});
    if (exp_rv) chk({tag, "_pc"}, redirect_pc, 32'h1040);
    chk({tag, "_wb"}, {31'b0, wb_valid}, 32'd0);
    tick;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_ready = 1'b0;
    instruction_i  = nop();
    tick; tick;
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_rv", {31'b0, redirect_valid}, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_exc", {31'b0, exc_valid}, 0);
    chk("rst_cnt", redirect_count, 0);
    reset = 1'b1;
    tick;

    // JAL 0x100+0x20, link 0x104 to x5
    redirect_ready = 1'b1;
    instruction_i = mk(FLOW_JAL, BEQ, 32'h100, 32'h20, 0, 0, 32'h104, 7'd5);
    tick;
    instruction_i = nop();
    tick;
    chk("jal_wb_valid", {31'b0, wb_valid}, 1);
    chk("jal_wb_addr", {25'b0, wb_addr}, 5);
    chk("jal_wb_data", wb_data, 32'h104);
    chk("jal_rv", {31'b0, redirect_valid}, 1);
    chk("jal_rpc", redirect_pc, 32'h120);
    tick;
    chk("jal_cnt", redirect_count, 1);
    chk("jal_rv_clr", {31'b0, redirect_valid}, 0);

    // JALR odd target, rd=0: no link write
    instruction_i = mk(FLOW_JALR, BEQ, 32'h2001, 32'h4, 0, 0, 32'h8, 7'd0);
    tick;
    instruction_i = nop();
    tick;
    chk("jalr_rpc", redirect_pc, 32'h2004);
    chk("jalr_rv", {31'b0, redirect_valid}, 1);
    chk("jalr_wb", {31'b0, wb_valid}, 0);
    tick;
    chk("jalr_cnt", redirect_count, 2);

    run_br("blt",   BLT,      32'hFFFFFFFF, 32'h1, 1'b1);
    run_br("bltu",  BLTU,     32'hFFFFFFFF, 32'h1, 1'b0);
    run_br("bgeu",  BGEU,     32'hFFFFFFFF, 32'h1, 1'b1);
    run_br("bge",   BGE,      32'hFFFFFFFF, 32'h1, 1'b0);
    run_br("bne",   BNE,      32'hFFFFFFFF, 32'h1, 1'b1);
    run_br("beq",   BEQ,      32'h5,        32'h5, 1'b1);
    run_br("binv",  BINVALID, 32'h5,        32'h5, 1'b0);
    chk("br_cnt", redirect_count, 6);

    // Hold with wrong-path redirects behind it
    redirect_ready = 1'b0;
    instruction_i = mk(FLOW_JAL, BEQ, 32'h200, 32'h0, 0, 0, 32'h4, 7'd1);
    tick;
    instruction_i = mk(FLOW_BRANCH, BEQ, 32'h300, 32'h0, 1, 1, 0, 0);
    tick;
    chk("hold_rv", {31'b0, redirect_valid}, 1);
    chk("hold_rpc0", redirect_pc, 32'h200);
    instruction_i = mk(FLOW_BRANCH, BEQ, 32'h400, 32'h0, 1, 1, 0, 0);
    tick;
    chk("hold_rpc1", redirect_pc, 32'h200);
    instruction_i = nop();
    tick;
    chk("hold_rpc2", redirect_pc, 32'h200);
    tick;
    chk("hold_rpc3", redirect_pc, 32'h200);
    tick;
    chk("hold_rpc4", redirect_pc, 32'h200);
    chk("hold_cnt0", redirect_count, 6);
    redirect_ready = 1'b1;
    tick;
    chk("hold_done_rv", {31'b0, redirect_valid}, 0);
    chk("hold_done_cnt", redirect_count, 7);
    tick;
    chk("no_wp_rv0", {31'b0, redirect_valid}, 0);
    tick;
    chk("no_wp_rv1", {31'b0, redirect_valid}, 0);
    chk("no_wp_cnt", redirect_count, 7);

    // Misaligned JAL target 0x102
    instruction_i = mk(FLOW_JAL, BEQ, 32'h100, 32'h2, 0, 0, 32'h104, 7'd3);
    tick;
    instruction_i = nop();
    tick;
    chk("mis_exc", {31'b0, exc_valid}, 1);
    chk("mis_exc_pc", exc_pc, 32'h102);
    chk("mis_rv", {31'b0, redirect_valid}, 0);
    chk("mis_wb", {31'b0, wb_valid}, 0);
    tick;
    chk("mis_pulse", {31'b0, exc_valid}, 0);

    // Reset while holding, with another op in flight in stage A
    redirect_ready = 1'b0;
    instruction_i = mk(FLOW_JAL, BEQ, 32'h500, 32'h0, 0, 0, 32'h504, 7'd4);
    tick;
    instruction_i = nop();
    tick;
    chk("rh_rv", {31'b0, redirect_valid}, 1);
    instruction_i = mk(FLOW_JAL, BEQ, 32'h600, 32'h0, 0, 0, 32'h604, 7'd6);
    tick;
    instruction_i = nop();
    reset = 1'b0;
    tick;
    chk("rh_rv0", {31'b0, redirect_valid}, 0);
    chk("rh_rpc0", redirect_pc, 0);
    chk("rh_cnt0", redirect_count, 0);
    chk("rh_wb0", {31'b0, wb_valid}, 0);
    chk("rh_wbd0", wb_data, 0);
    chk("rh_exc0", exc_pc, 0);
    reset = 1'b1;
    tick;
    chk("rh_wb1", {31'b0, wb_valid}, 0);
    chk("rh_rv1", {31'b0, redirect_valid}, 0);
    tick;
    chk("rh_wb2", {31'b0, wb_valid}, 0);
    chk("rh_rv2", {31'b0, redirect_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
